pinball_round_ctrl: RTL

Parametrised round/scoring controller for the pinball table. It runs the game FSM (idle, ready, in-play, settle, over) and tracks balls remaining. It synchronises and edge-detects N hole sensors and accumulates a saturating score with a consecutive-hit combo multiplier gated by the active hole mask. It sits between the debounced button one-pulses and the display, LED and group-select logic.

---
 rtl/pinball_round_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pinball_round_ctrl.sv
// Pinball round/scoring controller: game FSM, ball count, hole sensor
// synchronisation and a saturating score with a consecutive-hit combo multiplier.
module pinball_round_ctrl #(
    parameter int N_HOLES     = 8,
    parameter int BALLS       = 5,
    parameter int SCORE_W     = 15,
    parameter int PTS_HIT     = 10,
    parameter int MAX_MULT    = 4,
    parameter int SETTLE_CYC  = 2000000,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_p,
    input  logic               launch_p,
    input  logic [N_HOLES-1:0] hole,
    input  logic [N_HOLES-1:0] hole_mask,
    output logic [2:0]         state,
    output logic [3:0]         balls_left,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         last_hole,
    output logic               hit_valid,
    output logic               hit_scored,
    output logic               game_over
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SET_W-1:0]   SET_LAST  = SET_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [2:0]         COMBO_MAX = 3'(MAX_MULT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READY  = 3'd1,
        S_PLAY   = 3'd2,
        S_SETTLE = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         balls_q, balls_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         last_q, last_d;
    logic               hv_q, hv_d;
    logic               hs_q, hs_d;
    logic [2:0]         combo_q, combo_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [N_HOLES-1:0] sync1_q, sync2_q, prev_q;

    logic [N_HOLES-1:0] rise;
    logic               hit_any;
    logic [3:0]         hit_idx;
    logic               hit_masked;
    logic [2:0]         combo_inc;

    // Add PTS_HIT*mult to the score; one extra bit catches the carry for clamping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [2:0] mult);
        logic [31:0]        inc;
        logic [SCORE_W:0]   sum;
        inc = 32'(PTS_HIT) * 32'(mult);
        if (inc > 32'(SCORE_MAX)) begin
            return SCORE_MAX;
        end
        sum = {1'b0, a} + (SCORE_W + 1)'(inc);
        return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

    always_comb begin
        rise       = sync2_q & ~prev_q;
        hit_any    = |rise;
        hit_idx    = '0;
        hit_masked = 1'b0;
        // Descending scan so the lowest rising index is the one left standing.
        for (int i = N_HOLES - 1; i >= 0; i--) begin
            if (rise[i]) begin
                hit_idx    = 4'(i);
                hit_masked = hole_mask[i];
            end
        end
        combo_inc = (combo_q >= COMBO_MAX) ? COMBO_MAX : combo_q + 3'd1;
    end

    always_comb begin
        state_d = state_q;
        balls_d = balls_q;
        score_d = score_q;
        last_d  = last_q;
        hv_d    = 1'b0;
        hs_d    = 1'b0;
        combo_d = combo_q;
        tmo_d   = tmo_q;
        set_d   = set_q;
        case (state_q)
            S_IDLE: begin
                if (start_p) begin
                    state_d = S_READY;
                    balls_d = 4'(BALLS);
                    score_d = '0;
                    combo_d = '0;
                end
            end
            S_READY: begin
                if (launch_p) begin
                    state_d = S_PLAY;
                    balls_d = balls_q - 4'd1;
                    tmo_d   = '0;
                end
            end
            S_PLAY: begin
                if (hit_any) begin
                    state_d = S_SETTLE;
                    set_d   = '0;
                    last_d  = hit_idx;
                    hv_d    = 1'b1;
                    if (hit_masked) begin
                        combo_d = combo_inc;
                        score_d = sat_add(score_q, combo_inc);
                        hs_d    = 1'b1;
                    end else begin
                        combo_d = '0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_SETTLE;
                    set_d   = '0;
                    combo_d = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_SETTLE: begin
                if (set_q == SET_LAST) begin
                    state_d = (balls_q != 4'd0) ? S_READY : S_OVER;
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end
            S_OVER: begin
                if (start_p) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            balls_q <= '0;
            score_q <= '0;
            last_q  <= '0;
            hv_q    <= 1'b0;
            hs_q    <= 1'b0;
            combo_q <= '0;
            tmo_q   <= '0;
            set_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            balls_q <= balls_d;
            score_q <= score_d;
            last_q  <= last_d;
            hv_q    <= hv_d;
            hs_q    <= hs_d;
            combo_q <= combo_d;
            tmo_q   <= tmo_d;
            set_q   <= set_d;
            sync1_q <= hole;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign state      = state_q;
    assign balls_left = balls_q;
    assign score      = score_q;
    assign last_hole  = last_q;
    assign hit_valid  = hv_q;
    assign hit_scored = hs_q;
    assign game_over  = (state_q == S_OVER);

endmodule
